// File: rtl/phy_rx_sync_ctrl_if.sv
// rtl/phy_rx_sync_ctrl_if.sv - byte stream in, four lane outputs and sync status out
interface phy_rx_sync_ctrl_if;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic [8:0] data_0;
  logic [8:0] data_1;
  logic [8:0] data_2;
  logic [8:0] data_3;
  logic [1:0] lane_sel;
  logic       active;
  logic       sync_lost;

  modport master (
    output byte_in, byte_valid,
    input  data_0, data_1, data_2, data_3, lane_sel, active, sync_lost
  );

  modport slave (
    input  byte_in, byte_valid,
    output data_0, data_1, data_2, data_3, lane_sel, active, sync_lost
  );
endinterface

// File: rtl/phy_rx_sync_ctrl.sv
// rtl/phy_rx_sync_ctrl.sv - COM-based sync acquisition and round-robin lane dealing
module phy_rx_sync_ctrl #(
  parameter logic [7:0] COM_CHAR   = 8'hBC,
  parameter int         SYNC_COUNT = 4,
  parameter int         TIMEOUT    = 16
) (
  input  logic               clk_4f,
  input  logic               reset,
  phy_rx_sync_ctrl_if.slave  rx
);

  typedef enum logic [1:0] {LOOKING, SYNCING, ACTIVE} state_t;

  localparam logic [2:0] SYNC_CNT3  = 3'(SYNC_COUNT);
  localparam logic [7:0] GAP_MAX    = 8'(TIMEOUT);
  localparam logic [7:0] GAP_LAST   = 8'(TIMEOUT - 1);

  state_t     state, state_n;
  logic [2:0] com_cnt, com_cnt_n;
  logic [7:0] gap_cnt, gap_cnt_n;
  logic [1:0] lane_sel_q, lane_sel_n;
  logic [8:0] lane_q [4];
  logic [8:0] lane_n [4];
  logic       active_q, active_n;
  logic       lost_q, lost_n;
  logic       is_com, is_data;

  assign is_com  = rx.byte_valid && (rx.byte_in == COM_CHAR);
  assign is_data = rx.byte_valid && (rx.byte_in != COM_CHAR);

  always_ff @(posedge clk_4f) begin
    if (reset) begin
      state      <= LOOKING;
      com_cnt    <= '0;
      gap_cnt    <= '0;
      lane_sel_q <= '0;
      active_q   <= 1'b0;
      lost_q     <= 1'b0;
      for (int i = 0; i < 4; i++) lane_q[i] <= '0;
    end else begin
      state      <= state_n;
      com_cnt    <= com_cnt_n;
      gap_cnt    <= gap_cnt_n;
      lane_sel_q <= lane_sel_n;
      active_q   <= active_n;
      lost_q     <= lost_n;
      for (int i = 0; i < 4; i++) lane_q[i] <= lane_n[i];
    end
  end

  always_comb begin
    state_n    = state;
    com_cnt_n  = com_cnt;
    gap_cnt_n  = gap_cnt;
    lane_sel_n = lane_sel_q;
    lost_n     = 1'b0;
    // Lane valid bits are single-cycle pulses; payload bytes persist.
    for (int i = 0; i < 4; i++) lane_n[i] = {1'b0, lane_q[i][7:0]};

    case (state)
      LOOKING: begin
        if (is_com) begin
          if (SYNC_COUNT == 1) begin
            state_n    = ACTIVE;
            com_cnt_n  = '0;
            gap_cnt_n  = '0;
            lane_sel_n = '0;
          end else begin
            state_n   = SYNCING;
            com_cnt_n = 3'd1;
          end
        end
      end
      SYNCING: begin
        if (is_com) begin
          if (com_cnt + 3'd1 == SYNC_CNT3) begin
            state_n    = ACTIVE;
            com_cnt_n  = '0;
            gap_cnt_n  = '0;
            lane_sel_n = '0;
          end else begin
            com_cnt_n = com_cnt + 3'd1;
          end
        end else if (is_data) begin
          state_n   = LOOKING;
          com_cnt_n = '0;
        end
      end
      ACTIVE: begin
        if (!rx.byte_valid && gap_cnt == GAP_LAST) begin
          state_n    = LOOKING;
          com_cnt_n  = '0;
          gap_cnt_n  = '0;
          lane_sel_n = '0;
          lost_n     = 1'b1;
        end else if (!rx.byte_valid) begin
          if (gap_cnt != GAP_MAX) gap_cnt_n = gap_cnt + 8'd1;
        end else begin
          gap_cnt_n = '0;
          if (is_com) begin
            lane_sel_n = '0;
          end else begin
            lane_n[lane_sel_q] = {1'b1, rx.byte_in};
            lane_sel_n         = lane_sel_q + 2'd1;
          end
        end
      end
      default: begin
        state_n   = LOOKING;
        com_cnt_n = '0;
        gap_cnt_n = '0;
      end
    endcase

    active_n = (state_n == ACTIVE);
  end

  assign rx.data_0    = lane_q[0];
  assign rx.data_1    = lane_q[1];
  assign rx.data_2    = lane_q[2];
  assign rx.data_3    = lane_q[3];
  assign rx.lane_sel  = lane_sel_q;
  assign rx.active    = active_q;
  assign rx.sync_lost = lost_q;

endmodule
